// File: rtl/window_streamer.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift array turn a raster
// pixel stream into one neighbourhood per interior pixel, tagged with its centre address.
module window_streamer #(
   parameter int IMG_W = 800,
   parameter int IMG_H = 600,
   parameter int PIX_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PIX_W-1:0]   pix_in,
   input  logic               pix_valid,
   output logic               pix_ready,
   output logic [9*PIX_W-1:0] win_flat,
   output logic [18:0]        win_addr,
   output logic               win_valid,
   input  logic               win_ready,
   output logic               frame_done
);
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);

   logic [COL_W-1:0]   col;
   logic [ROW_W-1:0]   row;
   logic [PIX_W-1:0]   lb0 [IMG_W];
   logic [PIX_W-1:0]   lb1 [IMG_W];
   logic [PIX_W-1:0]   shift [9];
   logic [PIX_W-1:0]   next_shift [9];
   logic [9*PIX_W-1:0] next_flat;
   logic [PIX_W-1:0]   above1;
   logic [PIX_W-1:0]   above2;
   logic [18:0]        centre_addr;
   logic               accept;
   logic               qualify;
   logic               col_last;
   logic               row_last;
   logic               last_held;

   assign pix_ready   = !frame_done && (!win_valid || win_ready);
   assign accept      = pix_valid && pix_ready;
   assign col_last    = (col == COL_W'(IMG_W - 1));
   assign row_last    = (row == ROW_W'(IMG_H - 1));
   assign qualify     = accept && (row >= ROW_W'(2)) && (col >= COL_W'(2));
   assign above1      = lb0[col];
   assign above2      = lb1[col];
   assign centre_addr = 19'((32'(row) - 32'd1) * 32'(IMG_W) + 32'(col) - 32'd1);

   // Each window row slides left; the new right column is {two rows up, one row up, current}.
   always_comb begin
      for (int r = 0; r < 3; r++) begin
         next_shift[3*r]   = shift[3*r+1];
         next_shift[3*r+1] = shift[3*r+2];
         next_shift[3*r+2] = shift[3*r+2];
      end
      next_shift[2] = above2;
      next_shift[5] = above1;
      next_shift[8] = pix_in;
      next_flat = '0;
      for (int k = 0; k < 9; k++)
         next_flat[PIX_W*k +: PIX_W] = next_shift[k];
   end

   // Line buffers are plain RAMs without reset: every entry is rewritten before any window uses it.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb1[col] <= lb0[col];
         lb0[col] <= pix_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col <= '0;
         row <= '0;
         for (int k = 0; k < 9; k++)
            shift[k] <= '0;
      end else if (accept) begin
         shift <= next_shift;
         if (col_last) begin
            col <= '0;
            row <= row_last ? '0 : row + ROW_W'(1);
         end else begin
            col <= col + COL_W'(1);
         end
      end
   end

   // A qualifying accept reloads the output even while the current window is being consumed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         win_valid  <= 1'b0;
         win_flat   <= '0;
         win_addr   <= '0;
         last_held  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         if (win_valid && win_ready && last_held)
            frame_done <= 1'b1;
         if (qualify) begin
            win_valid <= 1'b1;
            win_flat  <= next_flat;
            win_addr  <= centre_addr;
            last_held <= col_last && row_last;
         end else if (win_ready) begin
            win_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_window_streamer.sv
// Self-checking bench for window_streamer: ramp and random frames checked against a
// reference that builds each expected window straight from a stored copy of the image.
module tb_window_streamer;
   localparam int IMG_W  = 800;
   localparam int IMG_H  = 8;
   localparam int PIX_W  = 8;
   localparam int FLAT_W = 9 * PIX_W;
   localparam int TOTAL  = IMG_W * IMG_H;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [PIX_W-1:0]  pix_in = '0;
   logic              pix_valid = 1'b0;
   logic              pix_ready;
   logic [FLAT_W-1:0] win_flat;
   logic [18:0]       win_addr;
   logic              win_valid;
   logic              win_ready = 1'b0;
   logic              frame_done;

   window_streamer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
      .clk(clk),
      .reset(reset),
      .pix_in(pix_in),
      .pix_valid(pix_valid),
      .pix_ready(pix_ready),
      .win_flat(win_flat),
      .win_addr(win_addr),
      .win_valid(win_valid),
      .win_ready(win_ready),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   logic [PIX_W-1:0]  img [TOTAL];
   int                vectors = 0;
   int                miscompares = 0;
   int                n;
   bit                m_valid;
   bit                m_last;
   bit                m_done;
   logic [18:0]       m_addr;
   logic [FLAT_W-1:0] m_flat;
   int                win_count;
   logic [18:0]       last_addr;

   task automatic checkOutput(input string tag, input logic [FLAT_W-1:0] got,
                              input logic [FLAT_W-1:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Drives one cycle, predicts the handshake and the window held after the edge.
   task automatic applyStimulus(input bit pv, input bit wr);
      bit exp_ready, acc, cons, held_last;
      int r, c;
      pix_valid = pv && (n < TOTAL || m_done);
      pix_in    = (n < TOTAL) ? img[n] : '0;
      win_ready = wr;
      #1;
      exp_ready = !m_done && (!m_valid || wr);
      checkOutput("pix_ready", pix_ready, exp_ready);
      acc       = pix_valid && exp_ready;
      cons      = m_valid && wr;
      held_last = m_last;
      if (cons) begin
         win_count++;
         last_addr = m_addr;
      end
      if (acc) begin
         r = n / IMG_W;
         c = n % IMG_W;
         n++;
         if (r >= 2 && c >= 2) begin
            m_valid = 1'b1;
            m_addr  = 19'((r - 1) * IMG_W + (c - 1));
            m_last  = (r == IMG_H - 1) && (c == IMG_W - 1);
            for (int dr = 0; dr < 3; dr++)
               for (int dc = 0; dc < 3; dc++)
                  m_flat[PIX_W*(3*dr+dc) +: PIX_W] = img[(r - 2 + dr) * IMG_W + (c - 2 + dc)];
         end else if (cons) begin
            m_valid = 1'b0;
         end
      end else if (cons) begin
         m_valid = 1'b0;
      end
      if (cons && held_last)
         m_done = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("win_valid", win_valid, m_valid);
      checkOutput("frame_done", frame_done, m_done);
      if (m_valid) begin
         checkOutput("win_addr", win_addr, m_addr);
         checkOutput("win_flat", win_flat, m_flat);
      end
   endtask

   task automatic applyReset();
      pix_valid = 1'b0;
      win_ready = 1'b0;
      #2 reset = 1'b1;
      #1;
      checkOutput("rst_win_valid", win_valid, 0);
      checkOutput("rst_win_flat", win_flat, 0);
      checkOutput("rst_win_addr", win_addr, 0);
      checkOutput("rst_frame_done", frame_done, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      checkOutput("rst_pix_ready", pix_ready, 1);
      n         = 0;
      m_valid   = 1'b0;
      m_last    = 1'b0;
      m_done    = 1'b0;
      m_addr    = '0;
      m_flat    = '0;
      win_count = 0;
      last_addr = '0;
   endtask

   initial begin
      bit seen_first, seen_wrap, bp_done;
      int guard;

      for (int i = 0; i < TOTAL; i++)
         img[i] = PIX_W'(i % 256);
      #3;
      applyReset();

      // Ramp: full throughput with one 5-cycle backpressure stall inside row 2.
      seen_first = 1'b0;
      seen_wrap  = 1'b0;
      bp_done    = 1'b0;
      guard      = 0;
      while (n < 4 * IMG_W && guard < 10000) begin
         guard++;
         if (n == 2 * IMG_W + 205 && !bp_done) begin
            repeat (5) applyStimulus(1'b1, 1'b0);
            bp_done = 1'b1;
         end else begin
            applyStimulus(1'b1, 1'b1);
         end
         if (m_valid && m_addr == 19'd801 && !seen_first) begin
            seen_first = 1'b1;
            checkOutput("first_addr", win_addr, 801);
            checkOutput("first_slot0", win_flat[7:0], 0);
            checkOutput("first_slot4", win_flat[39:32], 33);
            checkOutput("first_slot8", win_flat[71:64], 66);
         end
         if (m_valid && m_addr == 19'd1601 && !seen_wrap) begin
            seen_wrap = 1'b1;
            checkOutput("wrap_addr", win_addr, 1601);
            checkOutput("wrap_slot4", win_flat[39:32], 65);
         end
      end
      checkOutput("ramp_done", guard < 10000, 1);
      checkOutput("first_seen", seen_first, 1);
      checkOutput("wrap_seen", seen_wrap, 1);

      // Reset arrives while a window is held, then a random image streams with gaps.
      applyReset();
      for (int i = 0; i < TOTAL; i++)
         img[i] = PIX_W'($urandom);
      guard = 0;
      while (!m_done && guard < 60000) begin
         guard++;
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
      end
      checkOutput("frame_timeout", m_done, 1);
      checkOutput("win_count", win_count, (IMG_W - 2) * (IMG_H - 2));
      checkOutput("last_addr", last_addr, (IMG_H - 2) * IMG_W + IMG_W - 2);
      repeat (5) applyStimulus(1'b1, 1'b1);
      checkOutput("done_ready", pix_ready, 0);

      applyReset();
      checkOutput("done_cleared", frame_done, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/window_streamer.md
# window_streamer

Upstream neighbour of the sharpening datapath: accepts the 800x600 8-bit source image as a raster pixel stream, buffers two full lines internally, and emits one complete 3x3 neighbourhood per interior pixel, tagged with the output-memory address of its centre. It replaces nine-port random-access fetching of the input image with a single-port streaming front end feeding the sharpener / output-memory stage. It uses a valid/ready handshake on both sides and flags frame completion.

## Interface
- IMG_W, 800, pixels per line
- IMG_H, 600, lines per frame
- PIX_W, 8, bits per pixel
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all control state
- pix_in  in  PIX_W  source pixel, raster order (row 0 col 0 first)
- pix_valid  in  1  pix_in is valid
- pix_ready  out  1  block accepts pix_in this cycle
- win_flat  out  9*PIX_W  window; slot k at bits [PIX_W*k+PIX_W-1 : PIX_W*k], k = 3*dr+dc, slot 0 top-left, 4 centre, 8 bottom-right
- win_addr  out  19  raster address of centre pixel, (row-1)*IMG_W + (col-1)
- win_valid  out  1  win_flat/win_addr valid
- win_ready  in  1  downstream consumes window this cycle
- frame_done  out  1  sticky: last window of the frame consumed

## Operation
- Accept = pix_valid && pix_ready; pix_ready = !frame_done && (!win_valid || win_ready) (combinational).
- Counters col (0..IMG_W-1), row (0..IMG_H-1) index the accepted pixel; col wraps to 0 and row increments after col = IMG_W-1.
- Two line-buffer RAMs, IMG_W x PIX_W each, addressed by col: on accept, read lb1[col] (row-2) and lb0[col] (row-1), write lb1[col] <= lb0[col], lb0[col] <= pix_in. Reads use old contents (read-before-write).
- 3x3 shift array: on accept, each row shifts left one column; new right column = {lb1[col], lb0[col], pix_in} for window rows 0,1,2.
- Window qualifies when the accepted pixel has row >= 2 and col >= 2; then, on the next edge, win_flat is loaded with the shifted array, win_addr with the centre address, and win_valid is set.
- win_valid clears on win_ready unless a new qualifying accept happens in the same cycle (reload, stays 1).
- Windows at col 0/1 contain stale wrap-around columns and are never emitted; line-buffer contents are not reset and are never observable before being overwritten.
- Interior windows per frame: (IMG_W-2)*(IMG_H-2) = 477204; win_addr range 801..479198, strictly increasing, skipping edge columns.
- frame_done sets when the window from pixel (IMG_H-1, IMG_W-1) is consumed; holds until reset. No pixels accepted while set.

## Timing
- Reset values: pix_ready 1 (after reset deasserts), win_valid 0, win_flat 0, win_addr 0, frame_done 0, row 0, col 0, shift array 0.
- Latency: window visible 1 cycle after the accept edge of its bottom-right pixel.
- Full throughput: one pixel and one window per cycle with win_ready held high.
- Backpressure: win_valid && !win_ready -> pix_ready 0, win_flat/win_addr held stable, counters frozen.
- pix_valid low: no state change except win_valid clearing on consumption.
- Reset mid-frame: asynchronous return to reset values; next accepted pixel is treated as row 0 col 0.
- frame_done rises the cycle after the final win_valid && win_ready.

## Test plan
- Reset: assert reset mid-stream -> all outputs at reset values immediately; pix_ready 1 after release; win_valid stays 0 for the first 2*800+2 accepts.
- Ramp frame, pixel = (r*800+c) mod 256, win_ready 1 -> first window after accept of (2,2): slot0 0, slot4 33, slot8 66, win_addr 801.
- Backpressure: drop win_ready for 5 cycles with pix_valid high -> pix_ready 0 those cycles, window/address unchanged, no pixel lost (next window addr = previous+1).
- Line wrap: accepts of (3,0) and (3,1) -> no win_valid; (3,2) -> win_addr 1601, slot4 = pix(2,1) = 65.
- Full frame with random pix_valid/win_ready gaps -> exactly 477204 windows, last win_addr 479198, frame_done 1 the cycle after its consumption, pix_ready 0 thereafter.
- Simultaneous consume and reload: win_ready 1 on a qualifying accept -> win_valid stays 1, new address loaded, no window dropped.
